// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned multiplier that borrows the shared 16-bit ALU as a shift-add engine.
// Every multiply takes exactly 16 RUN steps, then a one-cycle DONE pulse.
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  output logic [3:0]  alu_Op,
  input  logic [15:0] alu_Out,
  input  logic        alu_Ofl
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] mc_q, mc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    alu_A   = '0;
    alu_B   = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          hi_d    = '0;
          lo_d    = mplier;
          mc_d    = mcand;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Operand B is gated rather than skipped so the step count never varies.
        alu_A = hi_q;
        alu_B = lo_q[0] ? mc_q : 16'h0000;
        hi_d  = {alu_Ofl, alu_Out[15:1]};
        lo_d  = {alu_Out[0], lo_q[15:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          prod_d  = {hi_d, lo_d};
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign prod     = prod_q;
  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;
  assign alu_Op   = OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: a reference ALU closes the loop, expected products are queued
// at start acceptance and checked by a per-cycle monitor.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] mcand, mplier;
  logic        busy, done;
  logic [31:0] prod;
  logic [15:0] alu_A, alu_B, alu_Out;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Ofl;
  logic [3:0]  alu_Op;

  alu_mul_seq #(.OP_ADD(4'b0100)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .prod     (prod),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_Cin  (alu_Cin),
    .alu_invA (alu_invA),
    .alu_invB (alu_invB),
    .alu_sign (alu_sign),
    .alu_Op   (alu_Op),
    .alu_Out  (alu_Out),
    .alu_Ofl  (alu_Ofl)
  );

  // Reference unsigned ALU: 17-bit sum, carry-out on alu_Ofl.
  assign {alu_Ofl, alu_Out} = {1'b0, alu_A} + {1'b0, alu_B};

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          m_end = -100;   // edge after which DONE is expected
  logic [31:0] m_prod = '0;
  logic [15:0] m_mc = '0, m_mp = '0;
  logic [31:0] q[$];
  bit          saw_ofl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of start acceptance and reset, from the sampled inputs.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_prod = '0;
      m_end  = -100;
    end else if (start && cyc >= m_end + 2) begin
      q.push_back(32'(mcand) * 32'(mplier));
      m_mc  = mcand;
      m_mp  = mplier;
      m_end = cyc + 16;
    end
  end

  always @(negedge clk) begin : mon
    int          k;
    logic        exp_done, exp_busy, exp_run;
    logic [31:0] mask, e;
    logic [15:0] exp_a, exp_b;
    exp_done = (cyc == m_end);
    exp_busy = (cyc >= m_end - 16) && (cyc <= m_end);
    exp_run  = exp_busy && !exp_done;
    k        = cyc - (m_end - 16);
    if (exp_done || done) begin
      if (q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        e      = q.pop_front();
        m_prod = e;
        chk("done", 32'(done), 32'(exp_done));
      end
    end else begin
      chk("done_idle", 32'(done), 32'd0);
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("prod", prod, m_prod);
    if (exp_run) begin
      // After k steps the accumulator holds the partial product of the low k multiplier bits.
      mask  = (32'd1 << k) - 32'd1;
      exp_a = 16'((32'(m_mc) * (32'(m_mp) & mask)) >> k);
      exp_b = m_mp[k] ? m_mc : 16'h0000;
      if (alu_Ofl) saw_ofl = 1'b1;
    end else begin
      exp_a = '0;
      exp_b = '0;
    end
    chk("alu_A", 32'(alu_A), 32'(exp_a));
    chk("alu_B", 32'(alu_B), 32'(exp_b));
    chk("alu_ctrl", 32'({alu_Cin, alu_invA, alu_invB, alu_sign, alu_Op}), 32'h4);
  end

  // Issue one accepted start; returns at the negedge of the first RUN cycle.
  task automatic op(input logic [15:0] a, input logic [15:0] b);
    while (cyc + 1 < m_end + 2) @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mcand  = 16'($urandom);
    mplier = 16'($urandom);
  endtask

  task automatic pulse_ignored();
    mcand  = 16'($urandom);
    mplier = 16'($urandom) | 16'h0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < m_end + 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (3) @(negedge clk);
    chk("reset_prod", prod, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op(16'd3, 16'd5);
    wait_idle();
    chk("prod_3x5", prod, 32'h0000000F);

    saw_ofl = 1'b0;
    op(16'hFFFF, 16'hFFFF);
    wait_idle();
    chk("prod_max", prod, 32'hFFFE0001);
    chk("ofl_seen", 32'(saw_ofl), 32'd1);

    op(16'h1234, 16'h0000);
    wait_idle();
    chk("prod_zero", prod, 32'h0);
    op(16'h1234, 16'h0001);
    wait_idle();
    chk("prod_one", prod, 32'h00001234);

    // Starts during RUN and DONE must be dropped.
    op(16'h0101, 16'h0202);
    t = m_end - 16;
    pulse_ignored();
    while (cyc < t + 7) @(negedge clk);
    pulse_ignored();
    while (cyc < m_end) @(negedge clk);
    pulse_ignored();
    chk("prod_ignored", prod, 32'h00020402);
    op(16'h0003, 16'h0007);
    wait_idle();
    chk("prod_t18", prod, 32'h00000015);

    // Abort mid-run; reset wins over a simultaneous start.
    op(16'h00FF, 16'h0100);
    t = m_end - 16;
    while (cyc < t + 7) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_prod", prod, 32'h0);
    op(16'h00FF, 16'h0100);
    wait_idle();
    chk("prod_after_abort", prod, 32'h0000FF00);

    for (int i = 0; i < 500; i++) begin
      op(16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that performs a 16x16 unsigned multiply by driving the shared 16-bit `alu` as a shift-add engine for 16 consecutive cycles. It sits beside the execute stage. It owns the ALU operand/control ports while busy and returns a 32-bit product with a one-cycle `done` pulse. No multiplier hardware is added; the only arithmetic is the ALU's 16-bit add.

## Interface
- `OP_ADD`, default `4'b0100`: `alu` Op encoding for A+B; driven constant on `alu_Op`.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous to `clk`, active-high.
- `start` input 1: request; accepted only in IDLE.
- `mcand` input 16: multiplicand, sampled on accepted start.
- `mplier` input 16: multiplier, sampled on accepted start.
- `busy` output 1: high while state is RUN or DONE.
- `done` output 1: one-cycle pulse; `prod` is valid.
- `prod` output 32: registered product; held until the next accepted start.
- `alu_A` output 16: ALU operand A.
- `alu_B` output 16: ALU operand B.
- `alu_Cin`, `alu_invA`, `alu_invB`, `alu_sign` output 1 each: tied 0.
- `alu_Op` output 4: tied to `OP_ADD`.
- `alu_Out` input 16: ALU sum.
- `alu_Ofl` input 1: with sign=0 this is the unsigned carry-out of bit 15.

## Operation
- Registers:
  - `hi[15:0]`: accumulator.
  - `lo[15:0]`: multiplier, shifting right.
  - `mc[15:0]`: multiplicand.
  - `cnt[4:0]`: step counter.
  - `state` ∈ {IDLE, RUN, DONE}.
- IDLE:
  - `alu_A` = 0 and `alu_B` = 0.
  - On `start` = 1: load `hi`=0, `lo`=`mplier`, `mc`=`mcand`, `cnt`=0; go to RUN.
- RUN, each cycle:
  - `alu_A` = `hi`; `alu_B` = `lo[0]` ? `mc` : 16'h0000. B is gated to zero, never skipped, so every multiply takes exactly 16 steps.
  - The 33-bit value {`alu_Ofl`, `alu_Out`, `lo`} is shifted right by 1:
    - `hi` <= {`alu_Ofl`, `alu_Out[15:1]`}
    - `lo` <= {`alu_Out[0]`, `lo[15:1]`}
  - `cnt` <= `cnt`+1.
  - On the step where `cnt` == 15: `prod` <= the post-shift {`hi`,`lo`} value (computed from that step's update), then go to DONE.
- DONE:
  - `done` = 1 for this one cycle; `alu_A` and `alu_B` = 0.
  - Unconditional transition to IDLE.
- `start` in RUN or DONE is ignored, not queued. The requester must wait for `busy` = 0.
- `mcand` and `mplier` are don't-care except in the accepting cycle.
- Product is exact: max 0xFFFF × 0xFFFF = 0xFFFE0001 fits 32 bits. The carry from `alu_Ofl` is never lost.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `prod`=0; `hi`, `lo`, `mc`, `cnt` = 0; `alu_A`=0, `alu_B`=0.
- `start` is sampled at edge T:
  - RUN occupies cycles T+1..T+16.
  - DONE (`done`=1) is cycle T+17.
  - IDLE resumes at T+18.
- `busy` is high from T+1 through T+17.
- `prod` updates at the edge ending cycle T+16; it is visible with `done` and stable thereafter.
- Minimum start-to-start spacing is 18 cycles. `start` in the `done` cycle is dropped; `start` in cycle T+18 is accepted.
- `alu_A` and `alu_B` are combinational from registered state. The ALU is combinational, so `alu_Out` and `alu_Ofl` settle within the same cycle.
- `rst` during RUN or DONE:
  - Next edge forces IDLE and clears `prod`.
  - No `done` pulse is issued for the aborted operation.
  - `rst` overrides a simultaneous `start`.

## Test plan
- Reset, then `start` with `mcand`=3, `mplier`=5 → `done` exactly 17 cycles after the start edge, `prod`=32'h0000000F, `busy` high for 17 cycles.
- `mcand`=16'hFFFF, `mplier`=16'hFFFF → `prod`=32'hFFFE0001. Check the carry path: `alu_Ofl`=1 on at least one step.
- `mcand`=16'h1234, `mplier`=0 → `prod`=0; `alu_B`=0 on all 16 RUN cycles. Then `mplier`=1 → `prod`=32'h00001234.
- Pulse `start` at RUN cycles 1, 8 and on the `done` cycle → ignored; `prod` is unchanged from the first operation. `start` at T+18 is accepted.
- `rst` asserted at RUN cycle 8 of 16'h00FF × 16'h0100 → next cycle `busy`=0, `prod`=0, no `done` pulse. A following full operation yields 32'h0000FF00.
- Drive `alu_Out`/`alu_Ofl` from a reference ALU model and random operands for 500 operations → `prod` == `mcand`×`mplier` every time. `alu_Op`=`OP_ADD` and all `alu_*` control bits are 0 throughout.
